imem_load_ctrl: RTL
===================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, meaning instruction words in the instruction memory.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the ADDI x0,x0,0 fill/return word.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load_start  input  1  one-cycle pulse requesting a program load.
REQ-006 SHALL have port load_len  input  9  number of words to load, sampled with load_start.
REQ-007 SHALL have port ld_valid  input  1  loader byte valid.
REQ-008 SHALL have port ld_data  input  8  loader byte, little-endian within each word.
REQ-009 SHALL have port ld_ready  output  1  byte accepted when ld_valid and ld_ready are both high.
REQ-010 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-011 SHALL have port mem_addr  output  8  memory word index, shared by reads and writes.
REQ-012 SHALL have port mem_wdata  output  32  memory write word.
REQ-013 SHALL have port mem_rdata  input  32  memory read word, combinational from mem_addr.
REQ-014 SHALL have port fetch_req  input  1  core fetch request.
REQ-015 SHALL have port fetch_addr  input  32  core PC as a byte address.
REQ-016 SHALL have port fetch_inst  output  32  registered fetched instruction.
REQ-017 SHALL have port fetch_valid  output  1  fetch_inst valid for one cycle.
REQ-018 SHALL have port fetch_err  output  1  misaligned or out-of-range fetch, qualified by fetch_valid.
REQ-019 SHALL have port core_stall  output  1  core held while the memory is owned by the loader.
REQ-020 SHALL have port busy  output  1  high in any state other than RUN.

Function
REQ-021 SHALL implement states CLEAR, IDLE, LOAD, RUN; reset enters IDLE.
REQ-022 IDLE: load_start with load_len!=0 SHALL go to LOAD (or to CLEAR when the feature in REQ-036 is on); with load_len==0 it SHALL go to RUN.
REQ-023 IDLE/RUN SHALL ignore load_start in LOAD and CLEAR; load_start in RUN SHALL restart the sequence per REQ-022.
REQ-024 ld_ready SHALL be high only in LOAD.
REQ-025 LOAD SHALL pack 4 accepted bytes into a word (first byte to [7:0]) and assert mem_we for exactly one cycle, with mem_addr equal to the word count so far.
REQ-026 After the write of word load_len-1, the controller SHALL go to RUN on the next cycle; extra bytes SHALL NOT be accepted.
REQ-027 load_len greater than IMEM_DEPTH SHALL be clamped to IMEM_DEPTH.
REQ-028 core_stall SHALL be high in CLEAR, IDLE, and LOAD; fetch_req SHALL be ignored there, with fetch_valid held at 0.
REQ-029 RUN: fetch_req SHALL drive mem_addr = fetch_addr[9:2], and fetch_inst/fetch_valid SHALL register on the next edge (latency 1); back-to-back fetches SHALL be accepted every cycle.
REQ-030 In RUN, fetch_addr[1:0]!=0 or fetch_addr>=4*IMEM_DEPTH SHALL return NOP_INST with fetch_err=1.
REQ-031 mem_we SHALL never be asserted in RUN or IDLE.

Reset
REQ-032 Asynchronous assertion of rst_n low SHALL force state=IDLE, with ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, fetch_inst=NOP_INST, fetch_valid=0, fetch_err=0, core_stall=1, busy=1.
REQ-033 Reset mid-LOAD SHALL discard the partial word and the count; memory contents already written SHALL be left as is.
REQ-034 Deassertion SHALL take effect on the first rising clk edge with rst_n high.

Configuration
REQ-035 The macro IMEM_LOAD_CLEAR_EN SHALL select whether the CLEAR state is compiled in.
REQ-036 With IMEM_LOAD_CLEAR_EN defined, CLEAR SHALL write NOP_INST to indices 0..IMEM_DEPTH-1, one per cycle, then enter LOAD; without it, CLEAR SHALL not exist and IDLE SHALL go directly to LOAD.

Structure
REQ-037 Package riscv_pkg SHALL hold NOP_INST, IMEM_DEPTH, and the state enum.
REQ-038 Byte-to-word assembly SHALL be the sub-module imem_word_packer (byte count, shift register, and word_valid pulse).

Verification
REQ-039 Load load_len=2 with bytes 93,00,50,00,13,01,30,00 -> mem writes idx0=0x00500093 and idx1=0x00300113, then RUN and core_stall=0.
REQ-040 RUN, fetch_addr=4 -> next cycle fetch_inst=0x00300113, fetch_valid=1, fetch_err=0.
REQ-041 fetch_addr=6, then fetch_addr=1024 -> NOP_INST with fetch_err=1 on each.
REQ-042 Reset after 5 bytes of a 3-word load -> IDLE and core_stall=1; a reload then writes from idx0.
REQ-043 With IMEM_LOAD_CLEAR_EN, load_len=1 -> 256 NOP writes precede the single loaded word; without the macro -> no NOP writes.
REQ-044 load_len=300 -> exactly 256 writes, then RUN.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
// Defining IMEM_LOAD_CLEAR_EN adds the CLEAR state (NOP fill before each load).
package riscv_pkg;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
`ifdef IMEM_LOAD_CLEAR_EN
    , ST_CLEAR = 2'd3
`endif
  } state_e;
endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: four accepted bytes produce one
// registered word with a single-cycle word_valid pulse.
module imem_word_packer
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_byte_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [1:0]        o_byte_cnt,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);
  logic [1:0]        r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_word;
  logic              r_word_valid;
  logic [WORD_W-1:0] w_shift_nxt;

  // New bytes enter at the top so the first byte ends up in [7:0].
  assign w_shift_nxt = {i_byte, r_shift[WORD_W-1:BYTE_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 2'd0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clr) begin
        r_cnt   <= 2'd0;
        r_shift <= '0;
      end else if (i_byte_valid) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_word       <= w_shift_nxt;
          r_word_valid <= 1'b1;
        end
      end
    end
  end

  assign o_byte_cnt   = r_cnt;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;
endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams loader bytes into the memory,
// then serves core fetches. Optional NOP pre-fill under IMEM_LOAD_CLEAR_EN.
module imem_load_ctrl #(
  parameter int unsigned IMEM_DEPTH = riscv_pkg::IMEM_DEPTH,
  parameter logic [31:0] NOP_INST   = riscv_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [8:0]  load_len,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_inst,
  output logic        fetch_valid,
  output logic        fetch_err,
  output logic        core_stall,
  output logic        busy
);
  import riscv_pkg::state_e;
  import riscv_pkg::ST_IDLE;
  import riscv_pkg::ST_LOAD;
  import riscv_pkg::ST_RUN;
`ifdef IMEM_LOAD_CLEAR_EN
  import riscv_pkg::ST_CLEAR;
`endif

  localparam int unsigned LEN_W       = 9;
  localparam logic [LEN_W-1:0] DEPTH_LEN   = LEN_W'(IMEM_DEPTH);
  localparam logic [31:0]      FETCH_LIMIT = 32'(4 * IMEM_DEPTH);

  state_e           r_state;
  logic             r_stall;
  logic             r_ld_ready;
  logic             r_mem_we;
  logic [7:0]       r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_fetch_inst;
  logic             r_fetch_valid;
  logic             r_fetch_err;
  logic             r_last;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_cnt;
`ifdef IMEM_LOAD_CLEAR_EN
  logic [LEN_W-1:0] r_clr_idx;
`endif

  logic        w_start;
  logic        w_accept;
  logic        w_final_byte;
  logic        w_fetch_run;
  logic        w_fetch_bad;
  logic [1:0]  w_pk_cnt;
  logic        w_word_valid;
  logic [31:0] w_word;

  assign w_start     = load_start & ((r_state == ST_IDLE) | (r_state == ST_RUN));
  assign w_accept    = ld_valid & r_ld_ready;
  assign w_fetch_run = fetch_req & (r_state == ST_RUN);
  assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) | (fetch_addr >= FETCH_LIMIT);
  // Drop ready on the very byte that completes the last word, so no extra byte slips in.
  assign w_final_byte = w_accept & (w_pk_cnt == 2'd3) & (r_word_cnt == (r_len - 9'd1));

  imem_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_start),
    .i_byte_valid (w_accept),
    .i_byte       (ld_data),
    .o_byte_cnt   (w_pk_cnt),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_stall       <= 1'b1;
      r_ld_ready    <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 8'd0;
      r_mem_wdata   <= 32'd0;
      r_fetch_inst  <= NOP_INST;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_last        <= 1'b0;
      r_len         <= '0;
      r_word_cnt    <= '0;
`ifdef IMEM_LOAD_CLEAR_EN
      r_clr_idx     <= '0;
`endif
    end else begin
      r_mem_we      <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_fetch_run) begin
            r_fetch_valid <= 1'b1;
            r_fetch_err   <= w_fetch_bad;
            r_fetch_inst  <= w_fetch_bad ? NOP_INST : mem_rdata;
          end
          if (load_start) begin
            r_len      <= (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
            r_word_cnt <= '0;
            r_last     <= 1'b0;
            if (load_len == 9'd0) begin
              r_state <= ST_RUN;
              r_stall <= 1'b0;
            end else begin
              r_stall <= 1'b1;
`ifdef IMEM_LOAD_CLEAR_EN
              r_state   <= ST_CLEAR;
              r_clr_idx <= '0;
`else
              r_state    <= ST_LOAD;
              r_ld_ready <= 1'b1;
`endif
            end
          end
        end
        ST_LOAD: begin
          if (w_final_byte) begin
            r_ld_ready <= 1'b0;
          end
          if (w_word_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_word_cnt[7:0];
            r_mem_wdata <= w_word;
            r_word_cnt  <= r_word_cnt + 9'd1;
            r_last      <= (r_word_cnt == (r_len - 9'd1));
          end
          // Leave LOAD the cycle after the final write strobe.
          if (r_last) begin
            r_state <= ST_RUN;
            r_stall <= 1'b0;
            r_last  <= 1'b0;
          end
        end
`ifdef IMEM_LOAD_CLEAR_EN
        ST_CLEAR: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_clr_idx[7:0];
          r_mem_wdata <= NOP_INST;
          r_clr_idx   <= r_clr_idx + 9'd1;
          if (r_clr_idx == (DEPTH_LEN - 9'd1)) begin
            r_state    <= ST_LOAD;
            r_ld_ready <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b1;
        end
      endcase
    end
  end

  // The memory read is combinational, so a RUN fetch steers the shared address directly.
  assign mem_addr    = w_fetch_run ? fetch_addr[9:2] : r_mem_addr;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign ld_ready    = r_ld_ready;
  assign fetch_inst  = r_fetch_inst;
  assign fetch_valid = r_fetch_valid;
  assign fetch_err   = r_fetch_err;
  assign core_stall  = r_stall;
  assign busy        = r_stall;
endmodule
